// File: rtl/exp_job_pkg.sv
// Shared register map, CTRL/STATUS bit positions and sequencer states
// for the exp_job_queue front end.
package exp_job_pkg;

  localparam int unsigned ADDR_OPX    = 0;
  localparam int unsigned ADDR_OPA    = 1;
  localparam int unsigned ADDR_CTRL   = 2;
  localparam int unsigned ADDR_STATUS = 3;
  localparam int unsigned ADDR_RESULT = 4;

  localparam int unsigned CTRL_PUSH    = 0;
  localparam int unsigned CTRL_FLUSH   = 1;
  localparam int unsigned CTRL_CLR_ERR = 2;
  localparam int unsigned CTRL_IRQ_EN  = 3;

  localparam int unsigned ST_CMD_FULL    = 0;
  localparam int unsigned ST_CMD_EMPTY   = 1;
  localparam int unsigned ST_RES_FULL    = 2;
  localparam int unsigned ST_RES_EMPTY   = 3;
  localparam int unsigned ST_BUSY        = 4;
  localparam int unsigned ST_ERR_OVF     = 5;
  localparam int unsigned ST_ERR_UDF     = 6;
  localparam int unsigned ST_CMD_CNT_LSB = 8;
  localparam int unsigned ST_RES_CNT_LSB = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    HOLD,
    WAIT
  } seq_state_t;

endpackage

// File: rtl/exp_fifo.sv
// Synchronous FIFO with flush; a push in the flush cycle lands in the
// freshly emptied storage.
module exp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr, wbase, rbase;
  logic [AW:0]      cbase;
  logic             do_push, do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  always_comb begin
    wbase   = flush ? '0 : wptr;
    rbase   = flush ? '0 : rptr;
    cbase   = flush ? '0 : count;
    do_push = push && (cbase != (AW+1)'(DEPTH));
    do_pop  = pop && !flush && !empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wbase + AW'(do_push);
      rptr  <= rbase + AW'(do_pop);
      count <= cbase + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wbase] <= din;
  end

endmodule

// File: rtl/exp_job_queue.sv
// Queued register front end for the modular-exponent core: command FIFO,
// one-job sequencer, result FIFO. Define EXP_JOB_IRQ_EN for the irq output.
module exp_job_queue
  import exp_job_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic              read,
  output logic [DATA_W-1:0] readdata,
  output logic              core_en,
  output logic [DATA_W-1:0] core_x,
  output logic [DATA_W-1:0] core_a,
  input  logic              core_ready,
  input  logic [DATA_W-1:0] core_p
`ifdef EXP_JOB_IRQ_EN
  ,
  output logic              irq
`endif
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  seq_state_t          state, state_n;
  logic [DATA_W-1:0]   opx, opa;
  logic                wr_opx, wr_opa, wr_ctrl, rd_result;
  logic                push_req, flush_req, clr_err;
  logic                cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic                res_push, res_pop, res_full, res_empty;
  logic [CW-1:0]       cmd_count, res_count;
  logic [2*DATA_W-1:0] cmd_head;
  logic [DATA_W-1:0]   res_head, status, rd_mux;
  logic                ovf_evt, udf_evt, err_ovf, err_udf, drop;

  assign wr_opx    = write && (address == ADDR_W'(ADDR_OPX));
  assign wr_opa    = write && (address == ADDR_W'(ADDR_OPA));
  assign wr_ctrl   = write && (address == ADDR_W'(ADDR_CTRL));
  assign rd_result = read && (address == ADDR_W'(ADDR_RESULT));
  assign push_req  = wr_ctrl && writedata[CTRL_PUSH];
  assign flush_req = wr_ctrl && writedata[CTRL_FLUSH];
  assign clr_err   = wr_ctrl && writedata[CTRL_CLR_ERR];

  // FLUSH in the same write empties the FIFO first, so that PUSH always lands.
  assign cmd_push = push_req && (flush_req || !cmd_full);
  assign ovf_evt  = push_req && cmd_full && !flush_req;
  assign res_pop  = rd_result && !res_empty;
  assign udf_evt  = rd_result && res_empty;

  exp_fifo #(.WIDTH(2*DATA_W), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_push),
    .pop   (cmd_pop),
    .flush (flush_req),
    .din   ({opx, opa}),
    .dout  (cmd_head),
    .count (cmd_count),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  exp_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_push),
    .pop   (res_pop),
    .flush (flush_req),
    .din   (core_p),
    .dout  (res_head),
    .count (res_count),
    .full  (res_full),
    .empty (res_empty)
  );

  always_comb begin
    state_n  = state;
    core_en  = 1'b0;
    cmd_pop  = 1'b0;
    res_push = 1'b0;
    unique case (state)
      IDLE:  if (!cmd_empty && !res_full && !flush_req) state_n = START;
      START: begin
        core_en = 1'b1;
        cmd_pop = 1'b1;
        state_n = HOLD;
      end
      HOLD:  state_n = WAIT;
      WAIT:  if (core_ready) begin
        res_push = !drop && !flush_req;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operands are latched on the launch edge so they are valid alongside core_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      core_x <= '0;
      core_a <= '0;
      drop   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == START) {core_x, core_a} <= cmd_head;
      if (state == WAIT && core_ready) drop <= 1'b0;
      else if (flush_req && state != IDLE) drop <= 1'b1;
    end
  end

  always_comb begin
    status = '0;
    status[ST_CMD_FULL]             = cmd_full;
    status[ST_CMD_EMPTY]            = cmd_empty;
    status[ST_RES_FULL]             = res_full;
    status[ST_RES_EMPTY]            = res_empty;
    status[ST_BUSY]                 = (state != IDLE);
    status[ST_ERR_OVF]              = err_ovf;
    status[ST_ERR_UDF]              = err_udf;
    status[ST_CMD_CNT_LSB +: 8]     = 8'(cmd_count);
    status[ST_RES_CNT_LSB +: 8]     = 8'(res_count);
  end

  always_comb begin
    rd_mux = '0;
    if (address == ADDR_W'(ADDR_STATUS)) rd_mux = status;
    else if (address == ADDR_W'(ADDR_RESULT) && !res_empty) rd_mux = res_head;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opx      <= '0;
      opa      <= '0;
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
      readdata <= '0;
    end else begin
      if (wr_opx) opx <= writedata;
      if (wr_opa) opa <= writedata;
      err_ovf <= ovf_evt || (err_ovf && !clr_err);
      err_udf <= udf_evt || (err_udf && !clr_err);
      if (read) readdata <= rd_mux;
    end
  end

`ifdef EXP_JOB_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= writedata[CTRL_IRQ_EN];
      irq <= irq_en && (!res_empty || err_ovf || err_udf);
    end
  end
`endif

endmodule

// File: tb/tb_exp_job_queue.sv
// Directed/randomised bench for exp_job_queue with a behavioural core model
// and a queue-based reference of expected results.
module tb_exp_job_queue;
  import exp_job_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 4;
  localparam int unsigned AW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] address = '0;
  logic          write = 1'b0;
  logic [DW-1:0] writedata = '0;
  logic          read = 1'b0;
  logic [DW-1:0] readdata;
  logic          core_en;
  logic [DW-1:0] core_x, core_a;
  logic          core_ready;
  logic [DW-1:0] core_p;
`ifdef EXP_JOB_IRQ_EN
  logic          irq;
`endif

  always #5 clk = ~clk;

  exp_job_queue #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .write      (write),
    .writedata  (writedata),
    .read       (read),
    .readdata   (readdata),
    .core_en    (core_en),
    .core_x     (core_x),
    .core_a     (core_a),
    .core_ready (core_ready),
    .core_p     (core_p)
`ifdef EXP_JOB_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0, en_cnt = 0, en_cyc = -1, rdy_cyc = -1, irq_cyc = -1;
  int wr_cyc = 0, rd_cyc = 0;
  logic rdy_q = 1'b0, irq_q = 1'b0;
  logic stall = 1'b0;
  int lat = 5, cnt = 0;
  logic [31:0] cx = '0, ca = '0;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] mexp(input logic [31:0] x, input logic [31:0] a);
    logic [31:0] r, b;
    r = 32'd1;
    b = x;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) r = r * b;
      b = b * b;
    end
    return r;
  endfunction

  function automatic logic [31:0] stat(input int cmdc, input int resc, input bit bsy,
                                       input bit ovf, input bit udf);
    logic [31:0] s;
    s = '0;
    s[0] = (cmdc == DEP);
    s[1] = (cmdc == 0);
    s[2] = (resc == DEP);
    s[3] = (resc == 0);
    s[4] = bsy;
    s[5] = ovf;
    s[6] = udf;
    s[15:8] = 8'(cmdc);
    s[23:16] = 8'(resc);
    return s;
  endfunction

  // Stand-in exponent core: result after lat cycles, held back while stall=1.
  always @(posedge clk) begin
    if (rst) begin
      core_ready <= 1'b1;
      cnt        <= 0;
      core_p     <= '0;
    end else if (core_en) begin
      core_ready <= 1'b0;
      cnt        <= lat;
      cx         <= core_x;
      ca         <= core_a;
    end else if (!core_ready) begin
      if (cnt != 0) cnt <= cnt - 1;
      else if (!stall) begin
        core_ready <= 1'b1;
        core_p     <= mexp(cx, ca);
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_en) begin
      en_cnt <= en_cnt + 1;
      en_cyc <= cyc;
    end
    rdy_q <= core_ready;
    if (core_ready && !rdy_q) rdy_cyc <= cyc;
`ifdef EXP_JOB_IRQ_EN
    irq_q <= irq;
    if (irq && !irq_q) irq_cyc <= cyc;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic wr(input int unsigned a, input logic [31:0] d);
    @(negedge clk);
    address = AW'(a);
    writedata = d;
    write = 1'b1;
    wr_cyc = cyc;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input int unsigned a, output logic [31:0] d);
    @(negedge clk);
    address = AW'(a);
    read = 1'b1;
    rd_cyc = cyc;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic push_job(input logic [31:0] x, input logic [31:0] a, input bit accept,
                          input logic [31:0] extra);
    wr(ADDR_OPX, x);
    wr(ADDR_OPA, a);
    wr(ADDR_CTRL, 32'd1 | extra);
    if (accept) exp_q.push_back(mexp(x, a));
  endtask

  task automatic wait_status(input logic [31:0] expv, input int limit, input string tag);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < limit; i++) begin
      rd(ADDR_STATUS, s);
      if (s === expv) break;
    end
    chk(tag, s, expv);
  endtask

  task automatic wait_en(input int target, input int limit, input string tag);
    for (int i = 0; i < limit && en_cnt < target; i++) @(negedge clk);
    chk(tag, en_cnt, target);
  endtask

  task automatic drain(input int n, input string tag);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      rd(ADDR_RESULT, d);
      chk(tag, d, (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, x, a;
    int base, n;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_core_en", {31'b0, core_en}, 32'd0);
    chk("rst_core_x", core_x, 32'd0);
    chk("rst_core_a", core_a, 32'd0);
    rd(ADDR_STATUS, d);
    chk("rst_status", d, 32'h0000_000A);
    rd(ADDR_RESULT, d);
    chk("udf_readdata", d, 32'd0);
    rd(ADDR_STATUS, d);
    chk("udf_status", d, stat(0, 0, 0, 0, 1));
    rd(7, d);
    chk("unmapped_read", d, 32'd0);
    wr(ADDR_CTRL, 32'd4);
    rd(ADDR_STATUS, d);
    chk("clr_err_status", d, stat(0, 0, 0, 0, 0));

    // Single job 3^5
    lat = 10;
    base = en_cnt;
    push_job(32'd3, 32'd5, 1'b1, 32'd0);
    wait_en(base + 1, 10, "first_launch");
    chk("launch_latency", en_cyc, wr_cyc + 2);
    chk("core_x_held", core_x, 32'd3);
    chk("core_a_held", core_a, 32'd5);
    wait_status(stat(0, 1, 0, 0, 0), 60, "first_done_status");
    chk("first_expected_243", exp_q[0], 32'd243);
    drain(1, "first_result");
    rd(ADDR_STATUS, d);
    chk("first_drained_status", d, stat(0, 0, 0, 0, 0));

    // Random batches
    for (int r = 0; r < 5; r++) begin
      lat = $urandom_range(2, 12);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) push_job($urandom, $urandom, 1'b1, 32'd0);
      wait_status(stat(0, n, 0, 0, 0), 300, "batch_status");
      drain(n, "batch_result");
    end

    // Overflow: one job in flight plus DEPTH queued, the next push rejected
    stall = 1'b1;
    lat = 3;
    base = en_cnt;
    for (int j = 0; j < 6; j++) push_job($urandom, $urandom, j < 5, 32'd0);
    rd(ADDR_STATUS, d);
    chk("ovf_status", d, stat(4, 0, 1, 1, 0));
    wr(ADDR_CTRL, 32'd5);
    rd(ADDR_STATUS, d);
    chk("ovf_beats_clr", d, stat(4, 0, 1, 1, 0));
    stall = 1'b0;
    wait_status(stat(1, 4, 0, 1, 0), 300, "res_full_status");
    repeat (10) @(negedge clk);
    chk("no_launch_res_full", en_cnt, base + 4);
    drain(1, "full_fifo_order");
    wait_en(base + 5, 10, "relaunch");
    chk("relaunch_latency", en_cyc, rd_cyc + 2);
    wait_status(stat(0, 4, 0, 1, 0), 100, "fifth_done_status");
    drain(4, "full_fifo_order");
    wr(ADDR_CTRL, 32'd4);

    // Result pop and result push in the same cycle
    stall = 1'b1;
    lat = 2;
    push_job($urandom, $urandom, 1'b1, 32'd0);
    push_job($urandom, $urandom, 1'b1, 32'd0);
    repeat (20) @(negedge clk);
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    repeat (20) @(negedge clk);
    stall = 1'b0;
    rd(ADDR_RESULT, d);
    chk("popush_read", d, exp_q.pop_front());
    wait_status(stat(0, 1, 0, 0, 0), 20, "popush_count");
    drain(1, "popush_second");

    // FLUSH while a job waits on the core
    stall = 1'b1;
    base = en_cnt;
    push_job($urandom, $urandom, 1'b1, 32'd0);
    push_job($urandom, $urandom, 1'b1, 32'd0);
    repeat (15) @(negedge clk);
    wr(ADDR_CTRL, 32'd2);
    exp_q.delete();
    rd(ADDR_STATUS, d);
    chk("flush_status", d, stat(0, 0, 1, 0, 0));
    stall = 1'b0;
    repeat (20) @(negedge clk);
    rd(ADDR_STATUS, d);
    chk("flush_dropped", d, stat(0, 0, 0, 0, 0));
    chk("flush_no_relaunch", en_cnt, base + 1);

    // FLUSH together with PUSH
    stall = 1'b1;
    push_job($urandom, $urandom, 1'b1, 32'd0);
    push_job($urandom, $urandom, 1'b1, 32'd0);
    repeat (15) @(negedge clk);
    x = $urandom;
    a = $urandom;
    wr(ADDR_OPX, x);
    wr(ADDR_OPA, a);
    wr(ADDR_CTRL, 32'd3);
    exp_q.delete();
    exp_q.push_back(mexp(x, a));
    rd(ADDR_STATUS, d);
    chk("flush_push_status", d, stat(1, 0, 1, 0, 0));
    stall = 1'b0;
    wait_status(stat(0, 1, 0, 0, 0), 100, "flush_push_done");
    drain(1, "flush_push_result");

`ifdef EXP_JOB_IRQ_EN
    chk("irq_idle", {31'b0, irq}, 32'd0);
    lat = 4;
    push_job($urandom, $urandom, 1'b1, 32'd8);
    wait_status(stat(0, 1, 0, 0, 0), 60, "irq_job_done");
    chk("irq_rise_cycle", irq_cyc, rdy_cyc + 2);
    chk("irq_high", {31'b0, irq}, 32'd1);
    drain(1, "irq_result");
    @(negedge clk);
    chk("irq_dropped", {31'b0, irq}, 32'd0);
    wr(ADDR_CTRL, 32'd0);
`endif

    // Reset in the middle of a job
    lat = 20;
    base = en_cnt;
    push_job($urandom, $urandom, 1'b1, 32'd0);
    wait_en(base + 1, 10, "pre_reset_launch");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_core_en", {31'b0, core_en}, 32'd0);
    chk("mid_rst_core_x", core_x, 32'd0);
    chk("mid_rst_readdata", readdata, 32'd0);
    rd(ADDR_STATUS, d);
    chk("mid_rst_status", d, stat(0, 0, 0, 0, 0));
    repeat (10) @(negedge clk);
    chk("mid_rst_no_launch", en_cnt, base + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
